// File: rtl/ir_pkg.sv
// Shared definitions for the IR prefetch buffer: immediate-format encodings,
// default field widths and the derived immediate width.
package ir_pkg;

    localparam logic [1:0] IMM_SEXT      = 2'b00;
    localparam logic [1:0] IMM_ZEXT      = 2'b01;
    localparam logic [1:0] IMM_SEXT_SHL1 = 2'b10;
    localparam logic [1:0] IMM_RAW       = 2'b11;

    localparam int unsigned WORD_W_DEF = 16;
    localparam int unsigned OP_W_DEF   = 4;
    localparam int unsigned RS_W_DEF   = 3;
    localparam int unsigned RD_W_DEF   = 3;
    localparam int unsigned DEPTH_DEF  = 4;

    // Whatever is left below opcode, rs and rd is the immediate field.
    function automatic int imm_width(input int word_w, input int op_w,
                                     input int rs_w, input int rd_w);
        return word_w - op_w - rs_w - rd_w;
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// DEPTH x WIDTH circular buffer with push, pop, flush and occupancy count.
// The head word is presented combinationally on rdata.
module ir_fifo
    import ir_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ir_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr_q];
    assign count   = cnt_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ir_prefetch_buffer.sv
// Instruction register fed by a prefetch queue, with field split and
// selectable immediate extension. Define IR_BYPASS_EN to let ld on an empty
// queue capture in_data directly.
module ir_prefetch_buffer
    import ir_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF,
    parameter int unsigned RS_W   = RS_W_DEF,
    parameter int unsigned RD_W   = RD_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int IMM_W          = imm_width(WORD_W, OP_W, RS_W, RD_W),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              ld,
    input  logic [1:0]        imm_mode,
    output logic              ir_valid,
    output logic [OP_W-1:0]   ir_op,
    output logic [RS_W-1:0]   ir_rs,
    output logic [RD_W-1:0]   ir_rd,
    output logic [WORD_W-1:0] ir_imm,
    output logic [CNT_W-1:0]  count
);

    if (IMM_W < 1) begin : g_bad_imm
        $error("ir_prefetch_buffer: opcode, rs and rd leave no immediate bits");
    end

    logic [WORD_W-1:0] ir_q;
    logic              ir_valid_q;
    logic [WORD_W-1:0] head;
    logic              full, empty;
    logic              push, pop, bypass;
    logic [WORD_W-1:0] sext, zext;

    always_comb begin
        bypass = 1'b0;
`ifdef IR_BYPASS_EN
        bypass = empty && in_valid && ld && !flush;
`endif
        // A bypassed word goes straight to the IR and must not also be queued.
        push = in_valid && in_ready && !flush && !bypass;
        pop  = ld && !empty && !flush;
    end

    assign in_ready = !full;

    ir_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else if (flush) begin
            ir_valid_q <= 1'b0;
        end else if (bypass) begin
            ir_q       <= in_data;
            ir_valid_q <= 1'b1;
        end else if (ld) begin
            if (!empty) begin
                ir_q       <= head;
                ir_valid_q <= 1'b1;
            end else begin
                ir_valid_q <= 1'b0;
            end
        end
    end

    assign ir_valid = ir_valid_q;
    assign ir_op    = ir_q[WORD_W-1 -: OP_W];
    assign ir_rs    = ir_q[WORD_W-OP_W-1 -: RS_W];
    assign ir_rd    = ir_q[WORD_W-OP_W-RS_W-1 -: RD_W];

    always_comb begin
        sext = '0;
        zext = '0;
        for (int i = 0; i < WORD_W; i++) begin
            if (i < IMM_W) begin
                sext[i] = ir_q[i];
                zext[i] = ir_q[i];
            end else begin
                sext[i] = ir_q[IMM_W-1];
                zext[i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (imm_mode)
            IMM_SEXT:      ir_imm = sext;
            IMM_ZEXT:      ir_imm = zext;
            IMM_SEXT_SHL1: ir_imm = {sext[WORD_W-2:0], 1'b0};
            IMM_RAW:       ir_imm = ir_q;
            default:       ir_imm = ir_q;
        endcase
    end

endmodule

// File: tb/tb_ir_prefetch_buffer.sv
// Self-checking bench for ir_prefetch_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_ir_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        ld = 1'b0;
    logic [1:0]  imm_mode = 2'b11;
    logic        ir_valid;
    logic [3:0]  ir_op;
    logic [2:0]  ir_rs;
    logic [2:0]  ir_rd;
    logic [15:0] ir_imm;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_q[$];
    logic [15:0] m_ir = '0;
    logic        m_irv = 1'b0;

    always #5 clk = ~clk;

    ir_prefetch_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .ld       (ld),
        .imm_mode (imm_mode),
        .ir_valid (ir_valid),
        .ir_op    (ir_op),
        .ir_rs    (ir_rs),
        .ir_rd    (ir_rd),
        .ir_imm   (ir_imm),
        .count    (count)
    );

    function automatic logic [15:0] ref_imm(input logic [15:0] ir, input logic [1:0] mode);
        int v;
        v = int'(ir) & 63;
        if (v >= 32) v = v - 64;
        case (mode)
            2'd0:    return 16'(v);
            2'd1:    return 16'(int'(ir) & 63);
            2'd2:    return 16'(v * 2);
            default: return ir;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle 1 ns after.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [15:0] d, input logic l);
        int  pre;
        logic rdy;
        logic byp;
        rst = r; flush = f; in_valid = iv; in_data = d; ld = l;
        @(posedge clk);
        pre = m_q.size();
        rdy = (pre != 4);
        byp = 1'b0;
        if (r) begin
            m_q.delete(); m_ir = '0; m_irv = 1'b0;
        end else if (f) begin
            m_q.delete(); m_irv = 1'b0;
        end else begin
`ifdef IR_BYPASS_EN
            if (pre == 0 && iv && l) begin
                byp = 1'b1; m_ir = d; m_irv = 1'b1;
            end
`endif
            if (!byp) begin
                if (l) begin
                    if (pre != 0) begin
                        m_ir = m_q.pop_front(); m_irv = 1'b1;
                    end else begin
                        m_irv = 1'b0;
                    end
                end
                if (iv && rdy) m_q.push_back(d);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 16'h0, 0);
        cycle(1, 0, 0, 16'h0, 0);
        rst = 0;
        n_vec++;
        if (count !== 3'd0 || in_ready !== 1'b1 || ir_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: count=%0d in_ready=%b ir_valid=%b want 0/1/0",
                     count, in_ready, ir_valid);
        end
        n_vec++;
        if ({ir_op, ir_rs, ir_rd} !== 10'd0 || ir_imm !== 16'h0) begin
            n_err++;
            $display("FAIL reset_fields: op=%h rs=%h rd=%h imm=%h want all 0",
                     ir_op, ir_rs, ir_rd, ir_imm);
        end
        imm_mode = 2'b00;
        cycle(0, 0, 1, 16'hA5F3, 0);
        n_vec++;
        if (count !== 3'd1) begin
            n_err++;
            $display("FAIL first_push_count: got %0d want 1", count);
        end
        cycle(0, 0, 0, 16'h0, 1);
        n_vec++;
        if (ir_op !== 4'hA || ir_rs !== 3'b010 || ir_rd !== 3'b111 || ir_imm !== 16'hFFF3
            || ir_valid !== 1'b1) begin
            n_err++;
            $display("FAIL first_load: op=%h rs=%b rd=%b imm=%h v=%b want A/010/111/FFF3/1",
                     ir_op, ir_rs, ir_rd, ir_imm, ir_valid);
        end
    endtask

    task automatic test_ext_modes();
        logic [15:0] want [4];
        want[0] = 16'hFFF4; want[1] = 16'h0034; want[2] = 16'hFFE8; want[3] = 16'h1234;
        cycle(0, 0, 1, 16'h1234, 0);
        cycle(0, 0, 0, 16'h0, 1);
        for (int m = 0; m < 4; m++) begin
            imm_mode = 2'(m);
            #1;
            n_vec++;
            if (ir_imm !== want[m]) begin
                n_err++;
                $display("FAIL ext_mode%0d: got %h want %h", m, ir_imm, want[m]);
            end
        end
    endtask

    task automatic test_fill_wrap();
        logic [15:0] tail [3];
        tail[0] = 16'h0011; tail[1] = 16'h0012; tail[2] = 16'h0013;
        imm_mode = 2'b11;
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 0, 1, 16'(k), 0);
            if (k >= 4) begin
                n_vec++;
                if (count !== 3'd4 || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_push%0d: count=%0d in_ready=%b want 4/0",
                             k, count, in_ready);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 1, 16'h0010 + 16'(k), 1);
            n_vec++;
            if (ir_imm !== 16'(k + 1) || ir_valid !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_ld%0d: ir=%h v=%b want %h/1", k, ir_imm, ir_valid,
                         16'(k + 1));
            end
        end
        n_vec++;
        if (count !== 3'd3) begin
            n_err++;
            $display("FAIL wrap_count: got %0d want 3", count);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 16'h0, 1);
            n_vec++;
            if (ir_imm !== tail[k]) begin
                n_err++;
                $display("FAIL refill_ld%0d: ir=%h want %h", k, ir_imm, tail[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(0, 0, 1, 16'h0A0A, 0);
        cycle(0, 0, 1, 16'h0B0B, 0);
        cycle(0, 0, 1, 16'h0C0C, 1);
        n_vec++;
        if (count !== 3'd2 || ir_imm !== 16'h0A0A) begin
            n_err++;
            $display("FAIL push_pop: count=%0d ir=%h want 2/0A0A", count, ir_imm);
        end
        cycle(0, 0, 0, 16'h0, 1);
        cycle(0, 0, 0, 16'h0, 1);
        n_vec++;
        if (ir_imm !== 16'h0C0C || count !== 3'd0) begin
            n_err++;
            $display("FAIL push_pop_order: ir=%h count=%0d want 0C0C/0", ir_imm, count);
        end
    endtask

    task automatic test_bubble();
        cycle(0, 0, 0, 16'h0, 1);
        n_vec++;
        if (ir_valid !== 1'b0 || ir_imm !== 16'h0C0C) begin
            n_err++;
            $display("FAIL bubble: v=%b ir=%h want 0/0C0C", ir_valid, ir_imm);
        end
        cycle(0, 0, 1, 16'h7C01, 1);
`ifdef IR_BYPASS_EN
        n_vec++;
        if (ir_valid !== 1'b1 || ir_imm !== 16'h7C01 || count !== 3'd0) begin
            n_err++;
            $display("FAIL bypass: v=%b ir=%h count=%0d want 1/7C01/0",
                     ir_valid, ir_imm, count);
        end
`else
        n_vec++;
        if (ir_valid !== 1'b0 || ir_imm !== 16'h0C0C || count !== 3'd1) begin
            n_err++;
            $display("FAIL empty_ld_push: v=%b ir=%h count=%0d want 0/0C0C/1",
                     ir_valid, ir_imm, count);
        end
        cycle(0, 0, 0, 16'h0, 1);
`endif
    endtask

    task automatic test_flush();
        cycle(0, 0, 1, 16'h1111, 0);
        cycle(0, 0, 1, 16'h2222, 0);
        cycle(0, 0, 1, 16'h3333, 0);
        cycle(0, 1, 1, 16'h4444, 1);
        n_vec++;
        if (count !== 3'd0 || ir_valid !== 1'b0 || ir_imm !== 16'h7C01) begin
            n_err++;
            $display("FAIL flush: count=%0d v=%b ir=%h want 0/0/7C01", count, ir_valid, ir_imm);
        end
        cycle(0, 0, 1, 16'h5555, 0);
        cycle(0, 0, 0, 16'h0, 1);
        n_vec++;
        if (ir_valid !== 1'b1 || ir_imm !== 16'h5555 || count !== 3'd0) begin
            n_err++;
            $display("FAIL post_flush: v=%b ir=%h count=%0d want 1/5555/0",
                     ir_valid, ir_imm, count);
        end
    endtask

    task automatic test_random();
        logic r, f, iv, l;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            f  = ($urandom_range(0, 15) == 0);
            iv = $urandom_range(0, 1) == 1;
            l  = $urandom_range(0, 1) == 1;
            imm_mode = 2'($urandom_range(0, 3));
            cycle(r, f, iv, 16'($urandom), l);
            n_vec++;
            if (ir_valid !== m_irv || count !== 3'(m_q.size())
                || in_ready !== (m_q.size() != 4)) begin
                n_err++;
                $display("FAIL rand_ctrl@%0d: v=%b count=%0d rdy=%b want %b/%0d/%b", i,
                         ir_valid, count, in_ready, m_irv, m_q.size(), m_q.size() != 4);
            end
            n_vec++;
            if ({ir_op, ir_rs, ir_rd} !== 10'(m_ir >> 6)
                || ir_imm !== ref_imm(m_ir, imm_mode)) begin
                n_err++;
                $display("FAIL rand_fields@%0d: op/rs/rd=%h imm=%h want %h/%h (mode %0d)", i,
                         {ir_op, ir_rs, ir_rd}, ir_imm, 10'(m_ir >> 6),
                         ref_imm(m_ir, imm_mode), imm_mode);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext_modes();
        test_fill_wrap();
        test_back_to_back();
        test_bubble();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
